calc_input_ctrl: RTL

CALC_INPUT_CTRL -- requirements
Module: calc_input_ctrl

---
 rtl/calc_pkg.sv | 26 ++
 rtl/debounce_pulse.sv | 65 ++++++
 rtl/calc_input_ctrl.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared constants for the calculator input controller: operation codes,
// FSM state encodings, debounce default and the operand sign helper.
package calc_pkg;

  localparam int unsigned DebCyclesDefault = 16;

  localparam logic [1:0] OpSom = 2'b00;
  localparam logic [1:0] OpSub = 2'b01;
  localparam logic [1:0] OpMul = 2'b10;
  localparam logic [1:0] OpDiv = 2'b11;

  typedef enum logic [2:0] {
    StWaitA  = 3'b000,
    StWaitOp = 3'b001,
    StWaitB  = 3'b010,
    StDone   = 3'b011
  } calc_state_e;

  // Sign-magnitude switches to two's complement; a negative zero folds to 8'h00.
  function automatic logic [7:0] signed_operand(input logic neg, input logic [6:0] mag);
    logic [7:0] ext;
    ext = {1'b0, mag};
    return neg ? (~ext + 8'd1) : ext;
  endfunction

endpackage

// File: rtl/debounce_pulse.sv
// Two-flop synchroniser, stability counter and rising-edge pulse for one
// bouncing button. After reset the button must first be seen released for
// DEB_CYCLES samples, so a button held through reset yields no event.
module debounce_pulse
  import calc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DebCyclesDefault
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic pulse_o
);

  localparam logic [7:0] CntMax = 8'(DEB_CYCLES - 1);

  logic       sync1_q;
  logic       sync2_q;
  logic       deb_q;
  logic       deb_last_q;
  logic       hold_q;
  logic       pulse_q;
  logic [7:0] cnt_q;

  // Synchronise, count consecutive differing samples, register the rising edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_last_q <= 1'b0;
      pulse_q    <= 1'b0;
      cnt_q      <= 8'd0;
      hold_q     <= 1'b1;
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      deb_last_q <= deb_q;
      pulse_q    <= deb_q & ~deb_last_q;
      if (hold_q) begin
        // Re-arm only once a stable release has been observed.
        if (sync2_q) begin
          cnt_q <= 8'd0;
        end else if (cnt_q == CntMax) begin
          hold_q <= 1'b0;
          cnt_q  <= 8'd0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end else if (sync2_q != deb_q) begin
        if (cnt_q == CntMax) begin
          deb_q <= sync2_q;
          cnt_q <= 8'd0;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
      end else begin
        cnt_q <= 8'd0;
      end
    end
  end

  assign pulse_o = pulse_q;

endmodule

// File: rtl/calc_input_ctrl.sv
// Calculator input controller: debounces the operator and enter buttons and
// sequences operand A, operator and operand B capture, all outputs registered.
module calc_input_ctrl
  import calc_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DebCyclesDefault
) (
  input  logic       clki,
  input  logic       rst,
  input  logic       butSOM,
  input  logic       butSUB,
  input  logic       butMUL,
  input  logic       butDIV,
  input  logic       enter,
  input  logic [6:0] binario,
  input  logic       sinal,
  output logic [7:0] operand,
  output logic       load_a,
  output logic       load_b,
  output logic [1:0] op_code,
  output logic       go,
  output logic [2:0] state,
  output logic       err
);

  logic [3:0]  ev_op;  // {DIV, MUL, SUB, SOM}
  logic        ev_enter;
  logic        op_single;
  logic        op_multi;
  logic [1:0]  op_enc;
  logic [7:0]  captured;

  calc_state_e state_q, state_d;
  logic [7:0]  operand_q, operand_d;
  logic [1:0]  op_code_q, op_code_d;
  logic        load_a_q, load_a_d;
  logic        load_b_q, load_b_d;
  logic        go_q, go_d;
  logic        err_q, err_d;

  debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_deb_som (
    .clk_i(clki), .rst_i(rst), .raw_i(butSOM), .pulse_o(ev_op[0])
  );
  debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sub (
    .clk_i(clki), .rst_i(rst), .raw_i(butSUB), .pulse_o(ev_op[1])
  );
  debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mul (
    .clk_i(clki), .rst_i(rst), .raw_i(butMUL), .pulse_o(ev_op[2])
  );
  debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_deb_div (
    .clk_i(clki), .rst_i(rst), .raw_i(butDIV), .pulse_o(ev_op[3])
  );
  debounce_pulse #(.DEB_CYCLES(DEB_CYCLES)) u_deb_enter (
    .clk_i(clki), .rst_i(rst), .raw_i(enter), .pulse_o(ev_enter)
  );

  // Classify operator events and encode the single-press case.
  always_comb begin
    op_multi  = (ev_op & (ev_op - 4'd1)) != 4'd0;
    op_single = (ev_op != 4'd0) && !op_multi;
    captured  = signed_operand(sinal, binario);
    op_enc    = op_code_q;
    unique case (ev_op)
      4'b0001: op_enc = OpSom;
      4'b0010: op_enc = OpSub;
      4'b0100: op_enc = OpMul;
      4'b1000: op_enc = OpDiv;
      default: op_enc = op_code_q;
    endcase
  end

  // Next-state and output decode; enter always wins over operator events.
  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    op_code_d = op_code_q;
    load_a_d  = 1'b0;
    load_b_d  = 1'b0;
    go_d      = load_b_q;
    err_d     = 1'b0;
    unique case (state_q)
      StWaitA: begin
        if (ev_enter) begin
          operand_d = captured;
          load_a_d  = 1'b1;
          state_d   = StWaitOp;
        end
      end
      StWaitOp: begin
        err_d = op_multi;
        if (ev_enter) begin
          operand_d = captured;
          load_a_d  = 1'b1;
        end else if (op_single) begin
          op_code_d = op_enc;
          state_d   = StWaitB;
        end
      end
      StWaitB: begin
        err_d = op_multi;
        if (ev_enter) begin
          operand_d = captured;
          load_b_d  = 1'b1;
          state_d   = StDone;
        end else if (op_single) begin
          op_code_d = op_enc;
        end
      end
      StDone: begin
        if (ev_enter) begin
          operand_d = captured;
          load_a_d  = 1'b1;
          state_d   = StWaitOp;
        end
      end
      default: state_d = StWaitA;
    endcase
  end

  // Output and state registers.
  always_ff @(posedge clki) begin
    if (rst) begin
      state_q   <= StWaitA;
      operand_q <= 8'h00;
      op_code_q <= OpSom;
      load_a_q  <= 1'b0;
      load_b_q  <= 1'b0;
      go_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      operand_q <= operand_d;
      op_code_q <= op_code_d;
      load_a_q  <= load_a_d;
      load_b_q  <= load_b_d;
      go_q      <= go_d;
      err_q     <= err_d;
    end
  end

  assign operand = operand_q;
  assign op_code = op_code_q;
  assign load_a  = load_a_q;
  assign load_b  = load_b_q;
  assign go      = go_q;
  assign err     = err_q;
  assign state   = state_q;

endmodule
